sensor_conditioner: RTL
=======================

# sensor_conditioner

Upstream front-end for the robot control FSM. Takes the four raw, asynchronous sensor lines (head, left, under, barrier), synchronizes each with a two-flop chain, and debounces each with its own counter. Drives clean, glitch-free `head`/`left`/`under`/`barrier` levels into the controller, with a `valid` flag and a one-cycle `changed` strobe. Cliff detection (`under`) uses a shorter debounce window because it is safety-critical.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before `head`, `left` or `barrier` change. Legal range 1..2^CNT_WIDTH-3.
- `UNDER_CYCLES`, default 2: consecutive stable cycles required before `under` changes. Legal range 1..DEBOUNCE_CYCLES.
- `CNT_WIDTH`, default 4: width of the debounce and fill counters.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. Release is synchronized externally.
- `raw_head` in 1: unsynchronized front obstacle sensor.
- `raw_left` in 1: unsynchronized left wall sensor.
- `raw_under` in 1: unsynchronized floor/cliff sensor.
- `raw_barrier` in 1: unsynchronized removable-barrier sensor.
- `head` out 1: debounced front sensor.
- `left` out 1: debounced left sensor.
- `under` out 1: debounced cliff sensor.
- `barrier` out 1: debounced barrier sensor.
- `valid` out 1: high once the outputs reflect real sensor state.
- `changed` out 1: one-cycle pulse on any debounced output update in RUN.

## Operation
- Synchronizer: per bit, `s1 <= raw`, `s2 <= s1`. Both flops reset to 0.
- Per-bit debounce, applied in RUN only. N = DEBOUNCE_CYCLES for head/left/barrier and UNDER_CYCLES for under. Each rising edge:
  - if `s2 == out`: `cnt <= 0`.
  - else if `cnt == N-1`: `out <= s2`, `cnt <= 0`.
  - else: `cnt <= cnt + 1`.
- A mismatch lasting fewer than N consecutive edges is rejected and the counter clears.
- The four bits are fully independent. Simultaneous changes on several bits are each handled by their own counter, and each bit commits when its own counter finishes.
- `changed` is registered. It is 1 on exactly the edge where at least one `out` bit toggles, otherwise 0. If several bits toggle on the same edge, `changed` still produces a single one-cycle pulse.
- State machine, two states:
  - FILL (reset state): `fill_cnt` counts up from 0. Debounce counters are held at 0. Outputs are held at 0 and `valid` = 0.
  - Transition FILL→RUN: on the edge where `fill_cnt == DEBOUNCE_CYCLES+1`, all `out <= s2` directly, `valid <= 1`, and `changed` stays 0.
  - RUN: normal debounce. RUN is left only by reset.
- Reset asserted mid-operation: all flops clear immediately and asynchronously. The block returns to FILL with outputs = 0, `valid` = 0, `changed` = 0, and all counters = 0.
- No counter saturates or wraps. The N-1 compare is always reached before overflow within the legal parameter range.

## Timing
- Reset values: `head`, `left`, `under`, `barrier`, `valid` and `changed` are all 0.
- `valid` rises on rising edge DEBOUNCE_CYCLES+2 after reset release, counting the first edge as 1.
- Latency: a raw level that is stable from before edge 1 commits to `out` on edge N+2. This gives 6 cycles for head/left/barrier and 4 cycles for under at default parameters.
- `changed` is coincident with the output update: both become visible after the same edge.
- Outputs are pure flop outputs, with no combinational path from raw inputs.

## Test plan
- Reset and fill: hold raw = 4'b0100 (head, left, under, barrier), then release `reset`.
  - Required: `valid` = 0 and outputs = 0 through edge 5.
  - Required: on edge 6, `valid` = 1 and outputs = 4'b0100.
  - Required: `changed` = 0 throughout.
- Clean transition: in RUN, raise `raw_head` and hold it.
  - Required: `head` goes 0→1 exactly on the 6th edge after the change.
  - Required: `changed` = 1 for that single cycle only.
- Glitch rejection: pulse `raw_barrier` high for 3 cycles, then low.
  - Required: `barrier` stays 0 and `changed` stays 0.
  - Then pulse it high for 4 or more cycles: required `barrier` = 1.
- Fast cliff path: raise `raw_under` and `raw_left` on the same cycle.
  - Required: `under` = 1 on edge 4 and `left` = 1 on edge 6.
  - Required: two separate `changed` pulses.
- Chatter: toggle `raw_left` every cycle for 20 cycles.
  - Required: `left` never changes and `changed` = 0 throughout.
- Reset mid-operation: assert `reset` while a counter is at 2 and `head` = 1.
  - Required: all outputs are 0 immediately, without waiting for a clock edge.
  - Required: after release, a full FILL sequence of 6 edges runs before `valid` = 1.

Source files
------------

// File: rtl/sensor_conditioner.sv
// Sensor front-end: two-flop synchronizers plus per-bit debounce for the four raw lines.
// The cliff sensor (under) uses a shorter window; outputs stay at 0 until the pipeline has filled.
module sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int UNDER_CYCLES    = 2,
   parameter int CNT_WIDTH       = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_head,
   input  logic raw_left,
   input  logic raw_under,
   input  logic raw_barrier,
   output logic head,
   output logic left,
   output logic under,
   output logic barrier,
   output logic valid,
   output logic changed
);

   typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CNT_WIDTH-1:0] DEB_LIM   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] UND_LIM   = CNT_WIDTH'(UNDER_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] FILL_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);

   // Bit order everywhere: {head, left, under, barrier}
   logic [3:0]           raw_s;
   logic [3:0]           s1_r;
   logic [3:0]           s2_r;
   logic [3:0]           out_r;
   logic [3:0]           out_next_s;
   logic [CNT_WIDTH-1:0] cnt_r      [4];
   logic [CNT_WIDTH-1:0] cnt_next_s [4];
   logic [CNT_WIDTH-1:0] fill_cnt_r;
   logic [CNT_WIDTH-1:0] fill_next_s;
   logic                 valid_r;
   logic                 valid_next_s;
   logic                 changed_r;
   logic                 changed_next_s;
   state_t               state_r;
   state_t               state_next_s;

   assign raw_s = {raw_head, raw_left, raw_under, raw_barrier};

   // Two-flop synchronizer chain for all four raw lines
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_r <= 4'b0000;
         s2_r <= 4'b0000;
      end else begin
         s1_r <= raw_s;
         s2_r <= s1_r;
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= FILL;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: RUN is only ever left through reset
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         FILL: begin
            if (fill_cnt_r == FILL_LAST) begin
               state_next_s = RUN;
            end else begin
               state_next_s = FILL;
            end
         end
         RUN:     state_next_s = RUN;
         default: state_next_s = FILL;
      endcase
   end

   // Output/datapath next values: fill sequencing and per-bit debounce counters
   always_comb begin
      out_next_s   = out_r;
      fill_next_s  = fill_cnt_r;
      valid_next_s = valid_r;
      for (int i = 0; i < 4; i++) begin
         cnt_next_s[i] = cnt_r[i];
      end
      case (state_r)
         FILL: begin
            fill_next_s = fill_cnt_r + CNT_ONE;
            for (int i = 0; i < 4; i++) begin
               cnt_next_s[i] = CNT_ZERO;
            end
            if (fill_cnt_r == FILL_LAST) begin
               out_next_s   = s2_r;
               valid_next_s = 1'b1;
            end else begin
               out_next_s   = 4'b0000;
               valid_next_s = 1'b0;
            end
         end
         RUN: begin
            for (int i = 0; i < 4; i++) begin
               if (s2_r[i] == out_r[i]) begin
                  cnt_next_s[i] = CNT_ZERO;
               end else if (cnt_r[i] == ((i == 1) ? UND_LIM : DEB_LIM)) begin
                  out_next_s[i] = s2_r[i];
                  cnt_next_s[i] = CNT_ZERO;
               end else begin
                  cnt_next_s[i] = cnt_r[i] + CNT_ONE;
               end
            end
         end
         default: begin
            out_next_s   = 4'b0000;
            fill_next_s  = CNT_ZERO;
            valid_next_s = 1'b0;
            for (int i = 0; i < 4; i++) begin
               cnt_next_s[i] = CNT_ZERO;
            end
         end
      endcase
      changed_next_s = (state_r == RUN) && (out_next_s != out_r);
   end

   // Datapath registers; all outputs come straight from these flops
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_r      <= 4'b0000;
         fill_cnt_r <= CNT_ZERO;
         valid_r    <= 1'b0;
         changed_r  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         out_r      <= out_next_s;
         fill_cnt_r <= fill_next_s;
         valid_r    <= valid_next_s;
         changed_r  <= changed_next_s;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= cnt_next_s[i];
         end
      end
   end

   assign head    = out_r[3];
   assign left    = out_r[2];
   assign under   = out_r[1];
   assign barrier = out_r[0];
   assign valid   = valid_r;
   assign changed = changed_r;

endmodule
